fft_frame_sequencer: RTL and testbench

Control block for the 8-point FFT datapath (sample bus → window → serial-to-parallel → width extension → FFT → output serializer). It counts incoming samples into frames and pulses the frame-load strobe that the sample bus and window stages consume. It waits out the fixed datapath latency, then steps the output bin index with a valid/ready handshake to the downstream consumer. It also flags samples lost while a frame is in flight.

---
 rtl/fft_ctrl_pkg.sv | 15 +
 rtl/fft_frame_sequencer_mod_counter.sv | 45 ++++
 rtl/fft_frame_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared types and default constants for the 8-point FFT control path.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        PROCESS = 2'd2,
        DRAIN   = 2'd3
    } seq_state_t;

    localparam int FFT_N_PTS    = 8;
    localparam int FFT_IDX_W    = 3;
    localparam int FFT_PIPE_LAT = 6;

endpackage

// File: rtl/fft_frame_sequencer_mod_counter.sv
// Modulo-MOD up-counter with synchronous clear, count enable and terminal-count flag.
module mod_counter #(
    parameter int WIDTH = 3,
    parameter int MOD   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign cnt = cnt_q;
    assign tc  = (cnt_q == WIDTH'(MOD - 1));

    // Next count: clear dominates, otherwise wrap at the modulus.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (tc) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame sequencer for the 8-point FFT: counts samples into frames, strobes load,
// waits out the datapath latency, then hands out bin indices under valid/ready.
module fft_frame_sequencer
    import fft_ctrl_pkg::*;
#(
    parameter int N_PTS    = FFT_N_PTS,
    parameter int IDX_W    = FFT_IDX_W,
    parameter int PIPE_LAT = FFT_PIPE_LAT,
    parameter int FC_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sample_valid,
    input  logic             clear_err,
    input  logic             out_ready,
    output logic             load,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             busy,
    output logic             overrun,
    output logic [FC_W-1:0]  frame_count
);

    localparam int LAT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    seq_state_t      state_q, state_d;
    logic            load_q, load_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic            busy_q, busy_d;
    logic            overrun_q, overrun_d;
    logic [FC_W-1:0] frame_count_q, frame_count_d;

    logic             samp_clr_s, samp_en_s, samp_tc_s;
    logic [IDX_W-1:0] samp_cnt_s;
    logic             lat_clr_s, lat_en_s, lat_tc_s;
    logic [LAT_W-1:0] lat_cnt_s;
    logic             idx_clr_s, idx_en_s, idx_tc_s;
    logic [IDX_W-1:0] idx_s;
    logic             hs_s;
    logic             ovr_set_s;
    logic             unused_cnt_s;

    mod_counter #(.WIDTH(IDX_W), .MOD(N_PTS)) u_samp_cnt (
        .clk   (clk),
        .rst_n (rst),
        .clr   (samp_clr_s),
        .en    (samp_en_s),
        .cnt   (samp_cnt_s),
        .tc    (samp_tc_s)
    );

    mod_counter #(.WIDTH(LAT_W), .MOD(PIPE_LAT)) u_lat_cnt (
        .clk   (clk),
        .rst_n (rst),
        .clr   (lat_clr_s),
        .en    (lat_en_s),
        .cnt   (lat_cnt_s),
        .tc    (lat_tc_s)
    );

    mod_counter #(.WIDTH(IDX_W), .MOD(N_PTS)) u_idx_cnt (
        .clk   (clk),
        .rst_n (rst),
        .clr   (idx_clr_s),
        .en    (idx_en_s),
        .cnt   (idx_s),
        .tc    (idx_tc_s)
    );

    // Only the terminal counts of the sample and latency counters steer the FSM.
    assign unused_cnt_s = ^{samp_cnt_s, lat_cnt_s};

    assign hs_s      = out_valid_q & out_ready;
    assign ovr_set_s = sample_valid & ((state_q == PROCESS) | (state_q == DRAIN));

    assign load        = load_q;
    assign out_valid   = out_valid_q;
    assign out_index   = idx_s;
    assign out_last    = out_last_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign frame_count = frame_count_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d       = state_q;
        load_d        = 1'b0;
        out_valid_d   = out_valid_q;
        out_last_d    = out_last_q;
        frame_count_d = frame_count_q;
        samp_clr_s    = 1'b0;
        samp_en_s     = 1'b0;
        lat_clr_s     = 1'b0;
        lat_en_s      = 1'b0;
        idx_clr_s     = 1'b0;
        idx_en_s      = 1'b0;

        case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                if (enable) begin
                    state_d    = CAPTURE;
                    samp_clr_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            CAPTURE: begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                // The completing sample beats a simultaneous enable drop.
                if (sample_valid && samp_tc_s) begin
                    state_d    = PROCESS;
                    load_d     = 1'b1;
                    lat_clr_s  = 1'b1;
                    samp_clr_s = 1'b1;
                end else if (!enable) begin
                    state_d    = IDLE;
                    samp_clr_s = 1'b1;
                end else if (sample_valid) begin
                    samp_en_s = 1'b1;
                end else begin
                    samp_en_s = 1'b0;
                end
            end
            PROCESS: begin
                out_last_d = 1'b0;
                lat_en_s   = 1'b1;
                if (lat_tc_s) begin
                    state_d     = DRAIN;
                    out_valid_d = 1'b1;
                    idx_clr_s   = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            DRAIN: begin
                if (hs_s) begin
                    idx_en_s = 1'b1;
                    if (idx_tc_s) begin
                        frame_count_d = frame_count_q + FC_W'(1);
                        out_valid_d   = 1'b0;
                        out_last_d    = 1'b0;
                        samp_clr_s    = 1'b1;
                        state_d       = enable ? CAPTURE : IDLE;
                    end else begin
                        out_last_d = (idx_s == IDX_W'(N_PTS - 2));
                    end
                end else begin
                    out_last_d = out_last_q;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);

        if (ovr_set_s) begin
            overrun_d = 1'b1;
        end else if (clear_err) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            load_q        <= 1'b0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            load_q        <= load_d;
            out_valid_q   <= out_valid_d;
            out_last_q    <= out_last_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            frame_count_q <= frame_count_d;
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Self-checking bench for fft_frame_sequencer: vector table for one frame, a bin
// scoreboard, and directed sequences for stalls, overrun, abort, wrap and reset.
module tb_fft_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        sample_valid = 1'b0;
    logic        clear_err = 1'b0;
    logic        out_ready = 1'b0;
    logic        load, out_valid, out_last, busy, overrun;
    logic [2:0]  out_index;
    logic [15:0] frame_count;

    logic        unused_load, unused_valid, unused_last, unused_busy, unused_ovr;
    logic [2:0]  unused_idx;
    logic [3:0]  fc_w4;

    int vectors = 0;
    int errors  = 0;
    int exp_fc  = 0;

    typedef struct packed {
        logic [2:0] idx;
        logic       last;
    } bin_t;
    bin_t sb_q[$];

    typedef struct packed {
        logic       en, sv, clr, rdy;
        logic       e_load, e_valid;
        logic [2:0] e_idx;
        logic       e_last, e_busy, e_ovr;
        logic [7:0] e_fc;
    } vec_t;
    vec_t tbl[24];

    fft_frame_sequencer u_dut (
        .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
        .clear_err(clear_err), .out_ready(out_ready), .load(load),
        .out_valid(out_valid), .out_index(out_index), .out_last(out_last),
        .busy(busy), .overrun(overrun), .frame_count(frame_count)
    );

    fft_frame_sequencer #(.FC_W(4)) u_dut_w4 (
        .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
        .clear_err(clear_err), .out_ready(out_ready), .load(unused_load),
        .out_valid(unused_valid), .out_index(unused_idx), .out_last(unused_last),
        .busy(unused_busy), .overrun(unused_ovr), .frame_count(fc_w4)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_frame();
        for (int i = 0; i < 8; i++) begin
            bin_t b;
            b.idx  = 3'(i);
            b.last = (i == 7);
            sb_q.push_back(b);
        end
    endtask

    // Apply inputs for the coming edge; a handshake at that edge pops the scoreboard.
    task automatic drive(input logic en, input logic sv, input logic clr, input logic rdy);
        enable       = en;
        sample_valid = sv;
        clear_err    = clr;
        out_ready    = rdy;
        if (out_valid && rdy) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_bin", 32'(out_index), 32'hFFFF_FFFF);
            end else begin
                bin_t e;
                e = sb_q.pop_front();
                chk("bin_index", 32'(out_index), 32'(e.idx));
                chk("bin_last", 32'(out_last), 32'(e.last));
                if (e.last) exp_fc++;
            end
        end
    endtask

    // From IDLE: enable, then 8 samples; returns on the load cycle (caller drives next).
    task automatic start_frame(input logic from_idle);
        if (from_idle) begin
            tick();
            drive(1'b1, 1'b0, 1'b0, 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("load_early", 32'(load), 32'd0);
            if (i == 7) push_frame();
            drive(1'b1, 1'b1, 1'b0, 1'b1);
        end
        tick();
        chk("load_strobe", 32'(load), 32'd1);
        chk("busy_process", 32'(busy), 32'd1);
    endtask

    task automatic wait_idle(input int max_cyc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1);
            tick();
            if (!busy) done = 1'b1;
        end
        chk("idle_reached", 32'(done), 32'd1);
    endtask

    task automatic chk_fc(input string name);
        chk(name, 32'(frame_count), 32'(exp_fc & 16'hFFFF));
        chk({name, "_w4"}, 32'(fc_w4), 32'(exp_fc & 4'hF));
    endtask

    initial begin
        bit found;

        // One frame: enable+8 samples, load at row 9 (T), bins at T+6..T+13.
        for (int r = 0; r < 24; r++) begin
            tbl[r].en      = (r <= 8);
            tbl[r].sv      = (r >= 1 && r <= 8);
            tbl[r].clr     = 1'b0;
            tbl[r].rdy     = 1'b1;
            tbl[r].e_load  = (r == 9);
            tbl[r].e_valid = (r >= 15 && r <= 22);
            tbl[r].e_idx   = (r >= 15 && r <= 22) ? 3'(r - 15) : 3'd0;
            tbl[r].e_last  = (r == 22);
            tbl[r].e_busy  = (r >= 1 && r <= 22);
            tbl[r].e_ovr   = 1'b0;
            tbl[r].e_fc    = (r == 23) ? 8'd1 : 8'd0;
        end

        repeat (3) tick();
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_index", 32'(out_index), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_fc", 32'(frame_count), 32'd0);
        rst = 1'b1;

        for (int r = 0; r < 24; r++) begin
            tick();
            chk("tbl_load", 32'(load), 32'(tbl[r].e_load));
            chk("tbl_valid", 32'(out_valid), 32'(tbl[r].e_valid));
            chk("tbl_index", 32'(out_index), 32'(tbl[r].e_idx));
            chk("tbl_last", 32'(out_last), 32'(tbl[r].e_last));
            chk("tbl_busy", 32'(busy), 32'(tbl[r].e_busy));
            chk("tbl_overrun", 32'(overrun), 32'(tbl[r].e_ovr));
            chk("tbl_fc", 32'(frame_count), 32'(tbl[r].e_fc));
            if (r == 8) push_frame();
            drive(tbl[r].en, tbl[r].sv, tbl[r].clr, tbl[r].rdy);
        end
        chk_fc("fc_after_table");

        // Back-pressure: stall three cycles on bin 2.
        start_frame(1'b1);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1);
            tick();
            if (out_valid && out_index == 3'd2) found = 1'b1;
        end
        chk("bp_reach_bin2", 32'(found), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            chk("bp_hold_index", 32'(out_index), 32'd2);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        wait_idle(40);
        chk_fc("fc_after_bp");

        // Overrun during PROCESS, clear, IDLE samples ignored, set beats clear.
        start_frame(1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk("ovr_set", 32'(overrun), 32'd1);
        wait_idle(40);
        chk_fc("fc_after_ovr1");
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk("ovr_cleared", 32'(overrun), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        chk("ovr_idle_ignored", 32'(overrun), 32'd0);
        start_frame(1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        chk("ovr_set_wins", 32'(overrun), 32'd1);
        wait_idle(40);
        chk_fc("fc_after_ovr2");

        // Abort after 5 samples, then a full frame is needed.
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            drive(1'b1, 1'b1, 1'b0, 1'b1);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_no_load", 32'(load), 32'd0);
        start_frame(1'b1);
        wait_idle(40);
        chk_fc("fc_after_abort");

        // Back-to-back: enable held, next frame starts right after the last bin.
        start_frame(1'b1);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1);
            tick();
            if (out_last) found = 1'b1;
        end
        chk("b2b_last_seen", 32'(found), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk("b2b_busy_held", 32'(busy), 32'd1);
        chk("b2b_valid_low", 32'(out_valid), 32'd0);
        chk_fc("fc_b2b_first");
        start_frame(1'b0);
        wait_idle(40);
        chk_fc("fc_b2b_second");

        // Enough frames to wrap the 4-bit counter instance.
        for (int f = 0; f < 12; f++) begin
            start_frame(1'b1);
            wait_idle(40);
            chk_fc("fc_loop");
        end
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset in the middle of DRAIN.
        start_frame(1'b1);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1);
            tick();
            if (out_valid && out_index == 3'd4) found = 1'b1;
        end
        chk("rst_reach_bin4", 32'(found), 32'd1);
        rst = 1'b0;
        #1;
        sb_q.delete();
        exp_fc = 0;
        chk("arst_load", 32'(load), 32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_index", 32'(out_index), 32'd0);
        chk("arst_last", 32'(out_last), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_overrun", 32'(overrun), 32'd0);
        chk_fc("arst_fc");
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1);
            tick();
            chk("arst_hold_valid", 32'(out_valid), 32'd0);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1);
            tick();
            chk("post_rst_valid", 32'(out_valid), 32'd0);
            chk("post_rst_busy", 32'(busy), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
